// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: start/operand request and busy/done/result response bundle
interface serial_add_sub_if #(parameter int WIDTH = 8);
    logic             start_i;
    logic             sub_i;
    logic             cin_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             ovf_o;
    modport master (output start_i, sub_i, cin_i, a_i, b_i,
                    input  busy_o, done_o, sum_o, cout_o, ovf_o);
    modport slave  (input  start_i, sub_i, cin_i, a_i, b_i,
                    output busy_o, done_o, sum_o, cout_o, ovf_o);
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle add/subtract, DIGIT bits per clock through a registered carry
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    serial_add_sub_if.slave  bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] opa_q, opb_q, res_q, sum_q;
    logic             carry_q, busy_q, done_q, cout_q, ovf_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT:0]   dsum_d;
    logic             cmsb_d, last_d;
    logic [WIDTH+DIGIT-1:0] cat_d;
    logic [WIDTH-1:0] shift_d;
    assign dsum_d  = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    // carry into the digit's top bit, recovered from its sum bit
    assign cmsb_d  = dsum_d[DIGIT-1] ^ opa_q[DIGIT-1] ^ opb_q[DIGIT-1];
    assign cat_d   = {dsum_d[DIGIT-1:0], res_q};
    assign shift_d = cat_d[WIDTH+DIGIT-1:DIGIT];
    assign last_d  = cnt_q == CW'(STEPS - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= bus.start_i;
                    state_q <= bus.start_i ? RUN : IDLE;
                    if (bus.start_i) begin
                        opa_q   <= bus.a_i;
                        opb_q   <= bus.sub_i ? ~bus.b_i : bus.b_i;
                        carry_q <= bus.sub_i ^ bus.cin_i;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    res_q   <= shift_d;
                    opa_q   <= opa_q >> DIGIT;
                    opb_q   <= opb_q >> DIGIT;
                    carry_q <= dsum_d[DIGIT];
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_d) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= shift_d;
                        cout_q  <= dsum_d[DIGIT];
                        ovf_q   <= dsum_d[DIGIT] ^ cmsb_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.sum_o  = sum_q;
    assign bus.cout_o = cout_q;
    assign bus.ovf_o  = ovf_q;
endmodule
